// File: rtl/vex_issue_seq.sv
// vex_issue_seq
// Issue sequencer between the vector register file and a vector execution
// pipe. One instruction is accepted at a time. Its operands are read element by
// element for indices 0..vl-1. Each element is presented to the pipe with
// valid/ready flow control, and the pipe's in-order results are written back
// with per-element masking. done_o pulses once the last write-back retires.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   instr_*                  instruction offer (valid/ready) and its fields
//   rf_rd_*                  operand read request: addresses and element index
//   rf_data_a/b_i, rf_mask_i read data, valid exactly one cycle after rf_rd_en_o
//   pipe_valid_o/ready_i     operand beat handshake toward the pipe
//   pipe_*_o                 beat operands, mask and latched instruction fields
//   pipe_wr_en_i/data_i      in-order result stream from the pipe
//   rf_wr_*                  register-file write port
//   done_o                   one-cycle completion pulse
module vex_issue_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int MICROOP_WIDTH = 5,
  parameter int VECTOR_LANES  = 8,
  parameter int VREG_AW       = 5,
  localparam int VLW          = $clog2(32 * VECTOR_LANES) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [MICROOP_WIDTH-1:0] instr_microop_i,
  input  logic [1:0]               instr_fu_i,
  input  logic [VREG_AW-1:0]       instr_vs1_i,
  input  logic [VREG_AW-1:0]       instr_vs2_i,
  input  logic [VREG_AW-1:0]       instr_vd_i,
  input  logic [DATA_WIDTH-1:0]    instr_imm_i,
  input  logic [VLW-1:0]           instr_vl_i,
  input  logic                     instr_mask_en_i,
  output logic                     rf_rd_en_o,
  output logic [VREG_AW-1:0]       rf_rd_addr_a_o,
  output logic [VREG_AW-1:0]       rf_rd_addr_b_o,
  output logic [VLW-1:0]           rf_rd_elem_o,
  input  logic [DATA_WIDTH-1:0]    rf_data_a_i,
  input  logic [DATA_WIDTH-1:0]    rf_data_b_i,
  input  logic                     rf_mask_i,
  output logic                     pipe_valid_o,
  input  logic                     pipe_ready_i,
  output logic                     pipe_mask_o,
  output logic [DATA_WIDTH-1:0]    pipe_data_a_o,
  output logic [DATA_WIDTH-1:0]    pipe_data_b_o,
  output logic [DATA_WIDTH-1:0]    pipe_imm_o,
  output logic [MICROOP_WIDTH-1:0] pipe_microop_o,
  output logic [1:0]               pipe_fu_o,
  output logic [VLW-1:0]           pipe_vl_o,
  input  logic                     pipe_wr_en_i,
  input  logic [DATA_WIDTH-1:0]    pipe_wr_data_i,
  output logic                     rf_wr_en_o,
  output logic [VREG_AW-1:0]       rf_wr_addr_o,
  output logic [VLW-1:0]           rf_wr_elem_o,
  output logic [DATA_WIDTH-1:0]    rf_wr_data_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [VLW-1:0] VL_ZERO = {VLW{1'b0}};
  localparam logic [VLW-1:0] VL_ONE  = {{(VLW-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [MICROOP_WIDTH-1:0] microop_r;
  logic [1:0]               fu_r;
  logic [VREG_AW-1:0]       vs1_r;
  logic [VREG_AW-1:0]       vs2_r;
  logic [VREG_AW-1:0]       vd_r;
  logic [DATA_WIDTH-1:0]    imm_r;
  logic [VLW-1:0]           vl_r;
  logic                     mask_en_r;
  logic [VLW-1:0]           rd_idx_r;
  logic [VLW-1:0]           wb_idx_r;
  logic                     inflight_r;

  // Operand FIFO, entry 0 is always the head so the beat comes straight from flops.
  logic [DATA_WIDTH-1:0]    op_a_r [2];
  logic [DATA_WIDTH-1:0]    op_b_r [2];
  logic [1:0]               op_m_r;
  logic [1:0]               op_cnt_r;

  // In-order mask FIFO pairing each fired beat with its later write-back.
  logic [3:0]               msk_q_r;
  logic [1:0]               msk_wp_r;
  logic [1:0]               msk_rp_r;
  logic [2:0]               msk_cnt_r;

  logic                     run_s;
  logic                     pipe_fire_s;
  logic                     push_s;
  logic                     eff_mask_s;
  logic [2:0]               occ_s;
  logic                     rd_en_s;
  logic                     wb_take_s;

  assign run_s       = (state_r == RUN);
  assign pipe_fire_s = (op_cnt_r != 2'd0) & pipe_ready_i;
  // Read data is only ever expected one cycle after an issued read.
  assign push_s      = inflight_r;
  assign eff_mask_s  = mask_en_r ? rf_mask_i : 1'b1;
  // Occupancy next cycle is fifo + inflight - fire; the fire term is moved to
  // the right-hand side so the compare cannot underflow.
  assign occ_s       = {1'b0, op_cnt_r} + {2'b00, inflight_r};
  assign rd_en_s     = run_s & (rd_idx_r < vl_r)
                     & (occ_s < (3'd2 + {2'b00, pipe_fire_s}))
                     & (msk_cnt_r != 3'd4);
  // Write-backs with no beat outstanding are stray and are dropped.
  assign wb_take_s   = run_s & pipe_wr_en_i & (msk_cnt_r != 3'd0);

  assign instr_ready_o  = (state_r == IDLE);
  assign done_o         = (state_r == DONE);
  assign rf_rd_en_o     = rd_en_s;
  assign rf_rd_addr_a_o = vs1_r;
  assign rf_rd_addr_b_o = vs2_r;
  assign rf_rd_elem_o   = rd_idx_r;
  assign pipe_valid_o   = (op_cnt_r != 2'd0);
  assign pipe_mask_o    = op_m_r[0];
  assign pipe_data_a_o  = op_a_r[0];
  assign pipe_data_b_o  = op_b_r[0];
  assign pipe_imm_o     = imm_r;
  assign pipe_microop_o = microop_r;
  assign pipe_fu_o      = fu_r;
  assign pipe_vl_o      = vl_r;
  assign rf_wr_en_o     = wb_take_s & msk_q_r[msk_rp_r];
  assign rf_wr_addr_o   = vd_r;
  assign rf_wr_elem_o   = wb_idx_r;
  assign rf_wr_data_o   = rf_wr_en_o ? pipe_wr_data_i : {DATA_WIDTH{1'b0}};

  // Control FSM: instruction latch, read/write-back counters, completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      microop_r  <= {MICROOP_WIDTH{1'b0}};
      fu_r       <= 2'b00;
      vs1_r      <= {VREG_AW{1'b0}};
      vs2_r      <= {VREG_AW{1'b0}};
      vd_r       <= {VREG_AW{1'b0}};
      imm_r      <= {DATA_WIDTH{1'b0}};
      vl_r       <= VL_ZERO;
      mask_en_r  <= 1'b0;
      rd_idx_r   <= VL_ZERO;
      wb_idx_r   <= VL_ZERO;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      case (state_r)
        IDLE: begin
          if (instr_valid_i) begin
            microop_r <= instr_microop_i;
            fu_r      <= instr_fu_i;
            vs1_r     <= instr_vs1_i;
            vs2_r     <= instr_vs2_i;
            vd_r      <= instr_vd_i;
            imm_r     <= instr_imm_i;
            vl_r      <= instr_vl_i;
            mask_en_r <= instr_mask_en_i;
            rd_idx_r  <= VL_ZERO;
            wb_idx_r  <= VL_ZERO;
            state_r   <= (instr_vl_i == VL_ZERO) ? DONE : RUN;
          end
        end
        RUN: begin
          if (rd_en_s) begin
            rd_idx_r <= rd_idx_r + VL_ONE;
          end
          if (wb_take_s) begin
            wb_idx_r <= wb_idx_r + VL_ONE;
            if ((wb_idx_r + VL_ONE) == vl_r) begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Operand FIFO: push returning read data, pop the head on pipe fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r   <= '{default: {DATA_WIDTH{1'b0}}};
      op_b_r   <= '{default: {DATA_WIDTH{1'b0}}};
      op_m_r   <= 2'b00;
      op_cnt_r <= 2'd0;
    end else if (push_s && pipe_fire_s) begin
      // Count unchanged; a full FIFO shifts and refills the tail.
      if (op_cnt_r == 2'd2) begin
        op_a_r[0] <= op_a_r[1];
        op_b_r[0] <= op_b_r[1];
        op_m_r[0] <= op_m_r[1];
        op_a_r[1] <= rf_data_a_i;
        op_b_r[1] <= rf_data_b_i;
        op_m_r[1] <= eff_mask_s;
      end else begin
        op_a_r[0] <= rf_data_a_i;
        op_b_r[0] <= rf_data_b_i;
        op_m_r[0] <= eff_mask_s;
      end
    end else if (push_s) begin
      if (op_cnt_r == 2'd0) begin
        op_a_r[0] <= rf_data_a_i;
        op_b_r[0] <= rf_data_b_i;
        op_m_r[0] <= eff_mask_s;
      end else begin
        op_a_r[1] <= rf_data_a_i;
        op_b_r[1] <= rf_data_b_i;
        op_m_r[1] <= eff_mask_s;
      end
      op_cnt_r <= op_cnt_r + 2'd1;
    end else if (pipe_fire_s) begin
      op_a_r[0] <= op_a_r[1];
      op_b_r[0] <= op_b_r[1];
      op_m_r[0] <= op_m_r[1];
      op_cnt_r  <= op_cnt_r - 2'd1;
    end else begin
      op_cnt_r <= op_cnt_r;
    end
  end

  // Mask FIFO: record each fired beat's mask, consume one per write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      msk_q_r   <= 4'b0000;
      msk_wp_r  <= 2'd0;
      msk_rp_r  <= 2'd0;
      msk_cnt_r <= 3'd0;
    end else begin
      if (pipe_fire_s) begin
        msk_q_r[msk_wp_r] <= op_m_r[0];
        msk_wp_r          <= msk_wp_r + 2'd1;
      end
      if (wb_take_s) begin
        msk_rp_r <= msk_rp_r + 2'd1;
      end
      case ({pipe_fire_s, wb_take_s})
        2'b10:   msk_cnt_r <= msk_cnt_r + 3'd1;
        2'b01:   msk_cnt_r <= msk_cnt_r - 3'd1;
        default: msk_cnt_r <= msk_cnt_r;
      endcase
    end
  end

endmodule

// File: doc/vex_issue_seq.md
# vex_issue_seq

Element issue sequencer that drives a vector execution pipe from the vector register file, on the initiator side of the pipe's valid/ready operand interface. It accepts one vector instruction at a time and reads operands element by element for indices 0..vl-1. It presents each element to the pipe with valid/ready flow control, then routes the pipe's in-order write-back stream to the register-file write port with per-element masking. It signals completion once the last write-back has retired.

## Interface
- DATA_WIDTH, 32, element width
- MICROOP_WIDTH, 5, microop width
- VECTOR_LANES, 8, lanes; sets VL width VLW = $clog2(32*VECTOR_LANES)+1
- VREG_AW, 5, vector register address width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  sequencer can accept
- instr_microop_i  in  MICROOP_WIDTH  operation
- instr_fu_i  in  2  functional-unit select
- instr_vs1_i / instr_vs2_i / instr_vd_i  in  VREG_AW  source A, source B, destination
- instr_imm_i  in  DATA_WIDTH  immediate
- instr_vl_i  in  VLW  element count
- instr_mask_en_i  in  1  1 = honour mask bits, 0 = all elements active
- rf_rd_en_o  out  1  operand read request
- rf_rd_addr_a_o / rf_rd_addr_b_o  out  VREG_AW  = latched vs1 / vs2
- rf_rd_elem_o  out  VLW  element index read
- rf_data_a_i / rf_data_b_i  in  DATA_WIDTH  operands, valid exactly 1 cycle after rf_rd_en_o
- rf_mask_i  in  1  v0 mask bit of that element, same timing
- pipe_valid_o  out  1  operand beat valid
- pipe_ready_i  in  1  pipe accepts
- pipe_mask_o  out  1  effective mask of beat
- pipe_data_a_o / pipe_data_b_o / pipe_imm_o  out  DATA_WIDTH  beat operands
- pipe_microop_o  out  MICROOP_WIDTH  operation
- pipe_fu_o  out  2  functional-unit select
- pipe_vl_o  out  VLW  latched instruction fields
- pipe_wr_en_i  in  1  pipe result valid (in order)
- pipe_wr_data_i  in  DATA_WIDTH  result
- rf_wr_en_o  out  1  register-file write
- rf_wr_addr_o  out  VREG_AW  = latched vd
- rf_wr_elem_o  out  VLW  element written
- rf_wr_data_o  out  DATA_WIDTH  = pipe_wr_data_i
- done_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - instr_ready_o=1.
  - On instr_valid_i, latch all instr fields and clear rd_idx, wb_idx.
  - Go to RUN, or to DONE if vl==0.
- RUN:
  - Operand FIFO depth 2 holds {a, b, mask}. inflight = rf_rd_en_o of previous cycle.
  - Read issue: rf_rd_en_o=1 when rd_idx<vl, (fifo_count + inflight − pipe_fire) < 2, and the mask FIFO is not full. rf_rd_elem_o=rd_idx; rd_idx increments.
  - Data returning from the register file is pushed into the operand FIFO the cycle it arrives.
  - Effective mask = instr_mask_en ? rf_mask_i : 1.
  - pipe_valid_o = FIFO not empty. The beat is the FIFO head. pipe_fire = pipe_valid_o & pipe_ready_i pops the head.
  - Each fire pushes the beat's mask into a depth-4 in-order mask FIFO. While it holds 4 entries, reads stall.
  - Write-back: on pipe_wr_en_i, pop the mask FIFO. rf_wr_en_o = pipe_wr_en_i & popped mask, combinational. rf_wr_elem_o = wb_idx; wb_idx increments on every pipe_wr_en_i, masked or not.
  - Transition to DONE when a write-back makes wb_idx == vl.
- DONE: done_o=1 for one cycle; instr_ready_o=0; go to IDLE.
- pipe_wr_en_i in IDLE/DONE, or with the mask FIFO empty, is ignored: no rf write and no counter change.
- Counters are VLW bits wide; vl max 32*VECTOR_LANES, so no wrap.
- Reset in any state:
  - Return to IDLE.
  - Flush both FIFOs and clear counters.
  - Discard in-flight read data.

## Timing
- Reset values: instr_ready_o=1; all other outputs 0 (data outputs 0).
- Accept in cycle 0 → first rf_rd_en_o in cycle 1 → pipe_valid_o in cycle 3 (FIFO registered).
- With pipe_ready_i=1 throughout, pipe_ready_i is never the bottleneck: one beat per cycle, beats in cycles 3..vl+2.
- The pipe returns results 1 cycle after fire, so write-backs occur in cycles 4..vl+3, DONE in cycle vl+4, and instr_ready_o=1 again in cycle vl+5.
- vl=0: DONE in cycle 1, IDLE in cycle 2, no reads.
- While pipe_valid_o=1 & pipe_ready_i=0, all pipe_* outputs stay stable.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.

## Test plan
- vl=4, mask_en=0, ready=1:
  - Reads in cycles 1–4; beats in cycles 3–6.
  - rf_wr_en_o in cycles 4–7 with elem 0..3.
  - done_o in cycle 8.
- vl=4, mask_en=1, rf_mask_i=1,0,1,0:
  - pipe_mask_o follows 1,0,1,0.
  - rf_wr_en_o only for elements 0 and 2.
  - done_o still fires after the 4th write-back.
- vl=6, pipe_ready_i low in cycles 3–7:
  - Beat 0 held stable.
  - Reads stop after the operand FIFO plus in-flight read reach 2.
  - All 6 elements are written in order 0..5 with no loss or duplicate.
- vl=0: instr accepted, done_o in cycle 1, no rf_rd_en_o, instr_ready_o=1 in cycle 2.
- rst asserted mid-RUN (vl=8, after 3 beats):
  - Next cycle: IDLE, all outputs at reset values.
  - A late pipe_wr_en_i causes no rf write.
  - A fresh vl=2 instruction then completes normally.
